bme280_sequencer: RTL and testbench

BME280_SEQUENCER -- requirements
Module: bme280_sequencer

---
 rtl/bme280_sequencer.sv | 228 ++++++++++++++++++++++
 tb/tb_bme280_sequencer.sv | 329 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bme280_sequencer.sv
// BME280 sequencer: configures the sensor once over an external I2C master,
// then burst-reads the raw pressure/temperature/humidity registers every period.
module bme280_sequencer #(
  parameter logic [6:0]  SLAVE_ADDR     = 7'h76,
  parameter logic [23:0] STARTUP_CYCLES = 24'd200000,
  parameter logic [23:0] PERIOD_CYCLES  = 24'd1000000,
  parameter logic [23:0] TIMEOUT_CYCLES = 24'd100000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic        i2c_en,
  output logic [6:0]  i2c_slave_addr,
  output logic        i2c_rw,
  output logic [7:0]  i2c_reg_addr,
  output logic [7:0]  i2c_wdata,
  input  logic [7:0]  i2c_rdata,
  input  logic        i2c_done,
  input  logic        i2c_nack,
  output logic [19:0] press_raw,
  output logic [19:0] temp_raw,
  output logic [15:0] hum_raw,
  output logic        sample_valid,
  output logic        busy,
  output logic        error
);

  typedef enum logic [3:0] {
    S_IDLE, S_RST_WR, S_STARTUP, S_ID_RD, S_HUM_WR,
    S_MEAS_WR, S_BURST, S_PUBLISH, S_PERIOD, S_ERROR
  } state_t;

  state_t      state_reg;
  logic        en_reg, rw_reg, sample_valid_reg, busy_reg, error_reg;
  logic [7:0]  reg_addr_reg, wdata_reg;
  logic [19:0] press_reg, temp_reg;
  logic [15:0] hum_reg;
  logic [23:0] startup_cnt_reg, period_cnt_reg, timeout_cnt_reg;
  logic [2:0]  byte_idx_reg;
  logic [7:0]  shadow_bytes [8];

  logic timeout_hit, done_ok, txn_fail, shadow_we;

  // True once a counter started at 0 has spent lim cycles (lim of 0 is immediate).
  function automatic logic reached(input logic [23:0] cnt, input logic [23:0] lim);
    return ({1'b0, cnt} + 25'd1) >= {1'b0, lim};
  endfunction

  assign timeout_hit = reached(timeout_cnt_reg, TIMEOUT_CYCLES);
  assign done_ok     = en_reg && i2c_done && !i2c_nack;
  assign txn_fail    = en_reg && ((i2c_done && i2c_nack) || (!i2c_done && timeout_hit) ||
                                  (done_ok && state_reg == S_ID_RD && i2c_rdata != 8'h60));
  assign shadow_we   = (state_reg == S_BURST) && done_ok;

  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_shadow
      logic [7:0] byte_reg;
      always_ff @(posedge clk or negedge rst) begin
        if (!rst)
          byte_reg <= '0;
        else if (shadow_we && byte_idx_reg == 3'(gi))
          byte_reg <= i2c_rdata;
      end
      assign shadow_bytes[gi] = byte_reg;
    end
  endgenerate

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg        <= S_IDLE;
      en_reg           <= 1'b0;
      rw_reg           <= 1'b0;
      reg_addr_reg     <= '0;
      wdata_reg        <= '0;
      press_reg        <= '0;
      temp_reg         <= '0;
      hum_reg          <= '0;
      sample_valid_reg <= 1'b0;
      busy_reg         <= 1'b0;
      error_reg        <= 1'b0;
      startup_cnt_reg  <= '0;
      period_cnt_reg   <= '0;
      timeout_cnt_reg  <= '0;
      byte_idx_reg     <= '0;
    end else begin
      sample_valid_reg <= 1'b0;
      if (period_cnt_reg != 24'hFFFFFF)
        period_cnt_reg <= period_cnt_reg + 24'd1;
      if (en_reg)
        timeout_cnt_reg <= timeout_cnt_reg + 24'd1;

      case (state_reg)
        S_IDLE: begin
          if (start) begin
            state_reg       <= S_RST_WR;
            busy_reg        <= 1'b1;
            error_reg       <= 1'b0;
            en_reg          <= 1'b1;
            rw_reg          <= 1'b0;
            reg_addr_reg    <= 8'hE0;
            wdata_reg       <= 8'hB6;
            timeout_cnt_reg <= '0;
          end
        end

        S_STARTUP: begin
          if (reached(startup_cnt_reg, STARTUP_CYCLES)) begin
            state_reg       <= S_ID_RD;
            en_reg          <= 1'b1;
            rw_reg          <= 1'b1;
            reg_addr_reg    <= 8'hD0;
            wdata_reg       <= 8'h00;
            timeout_cnt_reg <= '0;
          end else begin
            startup_cnt_reg <= startup_cnt_reg + 24'd1;
          end
        end

        S_RST_WR, S_ID_RD, S_HUM_WR, S_MEAS_WR, S_BURST: begin
          if (en_reg) begin
            if (txn_fail) begin
              en_reg    <= 1'b0;
              error_reg <= 1'b1;
              busy_reg  <= 1'b0;
              state_reg <= S_ERROR;
            end else if (done_ok) begin
              en_reg <= 1'b0;
            end
          // Request is low here: this is the mandatory idle cycle after a completion.
          end else begin
            case (state_reg)
              S_RST_WR: begin
                state_reg       <= S_STARTUP;
                startup_cnt_reg <= '0;
              end
              S_ID_RD: begin
                state_reg       <= S_HUM_WR;
                en_reg          <= 1'b1;
                rw_reg          <= 1'b0;
                reg_addr_reg    <= 8'hF2;
                wdata_reg       <= 8'h01;
                timeout_cnt_reg <= '0;
              end
              S_HUM_WR: begin
                state_reg       <= S_MEAS_WR;
                en_reg          <= 1'b1;
                rw_reg          <= 1'b0;
                reg_addr_reg    <= 8'hF4;
                wdata_reg       <= 8'h27;
                timeout_cnt_reg <= '0;
              end
              S_MEAS_WR: begin
                state_reg       <= S_BURST;
                en_reg          <= 1'b1;
                rw_reg          <= 1'b1;
                reg_addr_reg    <= 8'hF7;
                wdata_reg       <= 8'h00;
                byte_idx_reg    <= '0;
                period_cnt_reg  <= '0;
                timeout_cnt_reg <= '0;
              end
              S_BURST: begin
                if (byte_idx_reg == 3'd7) begin
                  state_reg        <= S_PUBLISH;
                  press_reg        <= {shadow_bytes[0], shadow_bytes[1], shadow_bytes[2][7:4]};
                  temp_reg         <= {shadow_bytes[3], shadow_bytes[4], shadow_bytes[5][7:4]};
                  hum_reg          <= {shadow_bytes[6], shadow_bytes[7]};
                  sample_valid_reg <= 1'b1;
                end else begin
                  byte_idx_reg    <= byte_idx_reg + 3'd1;
                  en_reg          <= 1'b1;
                  reg_addr_reg    <= reg_addr_reg + 8'd1;
                  timeout_cnt_reg <= '0;
                end
              end
              default: ;
            endcase
          end
        end

        S_PUBLISH: state_reg <= S_PERIOD;

        S_PERIOD: begin
          if (reached(period_cnt_reg, PERIOD_CYCLES)) begin
            if (start) begin
              state_reg       <= S_BURST;
              en_reg          <= 1'b1;
              rw_reg          <= 1'b1;
              reg_addr_reg    <= 8'hF7;
              wdata_reg       <= 8'h00;
              byte_idx_reg    <= '0;
              period_cnt_reg  <= '0;
              timeout_cnt_reg <= '0;
            end else begin
              state_reg <= S_IDLE;
              busy_reg  <= 1'b0;
            end
          end
        end

        S_ERROR: begin
          if (!start)
            state_reg <= S_IDLE;
        end

        default: begin
          state_reg <= S_IDLE;
          busy_reg  <= 1'b0;
          en_reg    <= 1'b0;
        end
      endcase
    end
  end

  assign i2c_en         = en_reg;
  assign i2c_slave_addr = SLAVE_ADDR;
  assign i2c_rw         = rw_reg;
  assign i2c_reg_addr   = reg_addr_reg;
  assign i2c_wdata      = wdata_reg;
  assign press_raw      = press_reg;
  assign temp_raw       = temp_reg;
  assign hum_raw        = hum_reg;
  assign sample_valid   = sample_valid_reg;
  assign busy           = busy_reg;
  assign error          = error_reg;

endmodule

// File: tb/tb_bme280_sequencer.sv
// Bench for bme280_sequencer: a behavioural I2C slave with random latency and
// data, plus a transaction-level model checked against the DUT every cycle.
module tb_bme280_sequencer;

  localparam logic [6:0]  SA = 7'h76;
  localparam int          ST = 20;
  localparam int          PC = 150;
  localparam int          TC = 40;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic        i2c_en, i2c_rw, i2c_done, i2c_nack;
  logic [6:0]  i2c_slave_addr;
  logic [7:0]  i2c_reg_addr, i2c_wdata, i2c_rdata;
  logic [19:0] press_raw, temp_raw;
  logic [15:0] hum_raw;
  logic        sample_valid, busy, error;

  bme280_sequencer #(
    .SLAVE_ADDR(SA), .STARTUP_CYCLES(24'(ST)),
    .PERIOD_CYCLES(24'(PC)), .TIMEOUT_CYCLES(24'(TC))
  ) dut (
    .clk(clk), .rst(rst), .start(start),
    .i2c_en(i2c_en), .i2c_slave_addr(i2c_slave_addr), .i2c_rw(i2c_rw),
    .i2c_reg_addr(i2c_reg_addr), .i2c_wdata(i2c_wdata), .i2c_rdata(i2c_rdata),
    .i2c_done(i2c_done), .i2c_nack(i2c_nack),
    .press_raw(press_raw), .temp_raw(temp_raw), .hum_raw(hum_raw),
    .sample_valid(sample_valid), .busy(busy), .error(error)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // Slave controls, written only by the main stimulus process.
  logic [7:0] id_value = 8'h60;
  logic [7:0] fixed_bytes [8];
  bit         rand_data = 1'b0;
  bit         withhold = 1'b0;
  int         lat_min = 0, lat_max = 4;
  int         nack_req = 0, spurious_req = 0;

  // Model state, written only by the compare process.
  int          ncyc = 0, sv_count = 0, last_sv = 0, prev_sv = 0;
  logic [19:0] held_p = '0, held_t = '0;
  logic [15:0] held_h = '0;

  task automatic chk(input string name, input logic [79:0] act, input logic [79:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic expire(input string name, input int lim);
    vectors++;
    miscompares++;
    $display("FAIL %s: event not seen within %0d cycles, expected it", name, lim);
  endtask

  // Behavioural I2C slave: answers each request after a random latency.
  initial begin
    int  cd;
    bit  active;
    int  nack_served, spurious_served;
    active = 0; cd = 0; nack_served = 0; spurious_served = 0;
    i2c_done = 1'b0; i2c_nack = 1'b0; i2c_rdata = 8'h00;
    forever begin
      @(posedge clk or negedge rst);
      if (!rst) begin
        active = 0; i2c_done = 1'b0; i2c_nack = 1'b0;
        continue;
      end
      #1;
      i2c_done = 1'b0;
      i2c_nack = 1'b0;
      if (!rst) begin
        active = 0;
        continue;
      end
      if (i2c_en && !active && !withhold) begin
        active = 1;
        cd = $urandom_range(lat_max, lat_min);
      end
      if (active) begin
        if (cd == 0) begin
          active = 0;
          i2c_done = 1'b1;
          if (i2c_reg_addr == 8'hD0)
            i2c_rdata = id_value;
          else if (i2c_reg_addr >= 8'hF7 && i2c_reg_addr <= 8'hFE)
            i2c_rdata = rand_data ? 8'($urandom) : fixed_bytes[i2c_reg_addr - 8'hF7];
          else
            i2c_rdata = 8'($urandom);
          if (nack_req != nack_served && i2c_rw && i2c_reg_addr == 8'hFA) begin
            i2c_nack = 1'b1;
            nack_served++;
          end
        end else begin
          cd--;
        end
      end else if (spurious_req != spurious_served && !i2c_en) begin
        i2c_done = 1'b1;
        i2c_rdata = 8'hFF;
        spurious_served++;
      end
    end
  end

  // Compare process: transaction-order model, burst byte capture, held outputs.
  initial begin
    int          step, bcnt, bi;
    bit          acc, prev_acc, prev_en;
    logic [16:0] prev_fields;
    logic [7:0]  bbytes [8];
    logic [7:0]  ea;
    step = 0; bcnt = 0; prev_acc = 0; prev_en = 0; prev_fields = '0;
    forever begin
      @(negedge clk);
      ncyc++;
      if (!rst) begin
        chk("reset_outputs", {i2c_en, i2c_rw, i2c_reg_addr, i2c_wdata, press_raw, temp_raw,
                              hum_raw, sample_valid, busy, error}, '0);
        step = 0; bcnt = 0; held_p = '0; held_t = '0; held_h = '0;
        prev_acc = 0; prev_en = 0;
        continue;
      end
      chk("slave_addr", i2c_slave_addr, SA);
      if (prev_acc) chk("en_drop_after_done", i2c_en, 1'b0);
      if (i2c_en && prev_en && !prev_acc)
        chk("request_stable", {i2c_rw, i2c_reg_addr, i2c_wdata}, prev_fields);
      if (i2c_en) chk("busy_during_request", busy, 1'b1);
      if (sample_valid) begin
        chk("burst_bytes_before_publish", bcnt, 8);
        held_p = {bbytes[0], bbytes[1], bbytes[2][7:4]};
        held_t = {bbytes[3], bbytes[4], bbytes[5][7:4]};
        held_h = {bbytes[6], bbytes[7]};
        sv_count++;
        prev_sv = last_sv;
        last_sv = ncyc;
        $display("sample %0d @%0d: press=%05h temp=%05h hum=%04h",
                 sv_count, ncyc, press_raw, temp_raw, hum_raw);
      end
      chk("raw_outputs", {press_raw, temp_raw, hum_raw}, {held_p, held_t, held_h});
      if (!busy) begin
        step = 0;
        bcnt = 0;
      end
      acc = i2c_en && i2c_done;
      if (acc) begin
        $display("txn %0d: rw=%0d reg=%02h wdata=%02h rdata=%02h nack=%0d",
                 step, i2c_rw, i2c_reg_addr, i2c_wdata, i2c_rdata, i2c_nack);
        case (step)
          0: chk("txn_soft_reset", {i2c_rw, i2c_reg_addr, i2c_wdata}, {1'b0, 8'hE0, 8'hB6});
          1: chk("txn_id_read", {i2c_rw, i2c_reg_addr}, {1'b1, 8'hD0});
          2: chk("txn_ctrl_hum", {i2c_rw, i2c_reg_addr, i2c_wdata}, {1'b0, 8'hF2, 8'h01});
          3: chk("txn_ctrl_meas", {i2c_rw, i2c_reg_addr, i2c_wdata}, {1'b0, 8'hF4, 8'h27});
          default: begin
            bi = (step - 4) % 8;
            if (bi == 0) bcnt = 0;
            ea = 8'hF7 + 8'(bi);
            chk("txn_burst_read", {i2c_rw, i2c_reg_addr}, {1'b1, ea});
            if (!i2c_nack) begin
              bbytes[bi] = i2c_rdata;
              bcnt++;
            end
          end
        endcase
        step++;
      end
      prev_acc = acc;
      prev_en = i2c_en;
      prev_fields = {i2c_rw, i2c_reg_addr, i2c_wdata};
    end
  end

  task automatic wait_sv(input string name, input int lim);
    bit got = 0;
    for (int n = 0; n < lim; n++) begin
      @(negedge clk);
      if (sample_valid) begin got = 1; break; end
    end
    #1;
    if (!got) expire(name, lim);
  endtask

  task automatic wait_busy_low(input string name, input int lim);
    bit got = 0;
    for (int n = 0; n < lim; n++) begin
      @(negedge clk);
      if (!busy) begin got = 1; break; end
    end
    #1;
    if (!got) expire(name, lim);
  endtask

  task automatic wait_req(input string name, input logic [7:0] addr, input int lim);
    bit got = 0;
    for (int n = 0; n < lim; n++) begin
      @(negedge clk);
      if (i2c_en && i2c_reg_addr == addr) begin got = 1; break; end
    end
    #1;
    if (!got) expire(name, lim);
  endtask

  initial begin
    int n, sv_snap, hits;
    logic [19:0] snap_p, snap_t;
    logic [15:0] snap_h;
    fixed_bytes[0] = 8'h65; fixed_bytes[1] = 8'h5A; fixed_bytes[2] = 8'hC0; fixed_bytes[3] = 8'h7E;
    fixed_bytes[4] = 8'hED; fixed_bytes[5] = 8'h00; fixed_bytes[6] = 8'h6C; fixed_bytes[7] = 8'h81;

    // Reset state, then idle with start low.
    repeat (3) @(negedge clk);
    chk("reset_state", {i2c_en, busy, error, sample_valid, press_raw}, '0);
    @(posedge clk); #1 rst = 1'b1;
    repeat (4) @(negedge clk);
    chk("idle_without_start", {i2c_en, busy}, 2'b00);

    // Nominal run with the reference sample bytes.
    start = 1'b1;
    wait_sv("first_sample", 1000);
    chk("ref_press_raw", press_raw, 20'h655AC);
    chk("ref_temp_raw", temp_raw, 20'h7EED0);
    chk("ref_hum_raw", hum_raw, 16'h6C81);
    chk("ref_busy_error", {busy, error}, 2'b10);

    // Fixed latency: successive samples exactly one period apart.
    rand_data = 1'b1;
    lat_min = 2; lat_max = 2;
    wait_sv("period_sample_2", 400);
    wait_sv("period_sample_3", 400);
    chk("sample_spacing_a", last_sv - prev_sv, PC);
    wait_sv("period_sample_4", 400);
    chk("sample_spacing_b", last_sv - prev_sv, PC);
    lat_min = 0; lat_max = 4;

    // start dropped mid-burst: that sample still publishes, then idle.
    wait_req("burst_f9", 8'hF9, 400);
    sv_snap = sv_count;
    start = 1'b0;
    wait_sv("publish_after_stop", 200);
    wait_busy_low("idle_after_stop", PC + 20);
    chk("stop_one_sample", sv_count - sv_snap, 1);
    chk("stop_no_error", error, 1'b0);
    hits = 0;
    repeat (20) begin @(negedge clk); if (i2c_en) hits++; end
    chk("stop_no_requests", hits, 0);

    // NACK on the 4th burst read: error, previous sample held.
    start = 1'b1;
    wait_sv("sample_before_nack", 1000);
    @(negedge clk); #1;
    snap_p = held_p; snap_t = held_t; snap_h = held_h;
    sv_snap = sv_count;
    nack_req++;
    wait_busy_low("error_after_nack", 600);
    chk("nack_error", {error, busy}, 2'b10);
    chk("nack_keeps_sample", {press_raw, temp_raw, hum_raw}, {snap_p, snap_t, snap_h});
    chk("nack_no_sample", sv_count, sv_snap);
    start = 1'b0;
    repeat (3) @(negedge clk);
    chk("error_sticky_in_idle", {error, busy}, 2'b10);

    // Wrong chip ID.
    id_value = 8'h58;
    start = 1'b1;
    wait_req("bad_id_read", 8'hD0, 200);
    wait_busy_low("error_after_bad_id", 50);
    chk("bad_id_error", {error, busy}, 2'b10);
    repeat (10) @(negedge clk);
    chk("error_holds_with_start", {error, busy, i2c_en}, 3'b100);
    chk("bad_id_no_sample", sv_count, sv_snap);
    start = 1'b0;
    id_value = 8'h60;
    repeat (3) @(negedge clk);
    start = 1'b1;
    wait_req("restart_soft_reset", 8'hE0, 10);
    chk("restart_clears_error", {error, busy, i2c_rw}, 3'b010);

    // Withheld completion: request dropped after exactly TC cycles.
    start = 1'b0;
    wait_busy_low("idle_before_timeout", 4 * PC);
    withhold = 1'b1;
    start = 1'b1;
    wait_req("timeout_request", 8'hE0, 10);
    n = 1;
    while (n < TC + 20) begin
      @(negedge clk);
      if (!i2c_en) break;
      n++;
    end
    #1;
    chk("timeout_en_cycles", n, TC);
    chk("timeout_error", {error, busy}, 2'b10);

    // Stray completion while no request is pending is ignored.
    withhold = 1'b0;
    start = 1'b0;
    repeat (3) @(negedge clk);
    start = 1'b1;
    wait_req("stray_soft_reset", 8'hE0, 10);
    n = 0;
    while (i2c_en && n < 20) begin @(negedge clk); n++; end
    spurious_req++;
    wait_sv("sample_after_stray", 1000);
    chk("stray_no_error", error, 1'b0);

    // Asynchronous reset mid-burst, then full reconfiguration.
    wait_req("burst_fb", 8'hFB, 400);
    #1 rst = 1'b0;
    #1;
    chk("async_reset_outputs", {i2c_en, i2c_rw, i2c_reg_addr, i2c_wdata, press_raw, temp_raw,
                                hum_raw, sample_valid, busy, error}, '0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    wait_req("reconfig_soft_reset", 8'hE0, 10);
    chk("reconfig_write", {i2c_rw, i2c_wdata}, {1'b0, 8'hB6});
    wait_sv("sample_after_reset", 1000);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
